la_status_arbiter: RTL and testbench



---
 rtl/la_status_arbiter_if.sv | 27 ++
 rtl/la_status_arbiter.sv | 129 ++++++++++++
 tb/tb_la_status_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/la_status_arbiter_if.sv
// Status-field sharing bus between the requesters and the checkbits arbiter.
// The arbiter side uses the slave modport. The requester/test side uses master.
interface la_status_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int IDX_W = 2
);
  logic                   enable;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic [WIDTH-1:0]       status_out;
  logic [WIDTH-1:0]       status_oeb;
  logic                   busy;
  logic [IDX_W-1:0]       owner;

  modport slave (
    input  enable, req, req_data,
    output gnt, done, status_out, status_oeb, busy, owner
  );

  modport master (
    output enable, req, req_data,
    input  gnt, done, status_out, status_oeb, busy, owner
  );
endinterface

// File: rtl/la_status_arbiter.sv
// Round-robin owner of the 16-bit checkbits pad field. Each granted word is
// held for HOLD_CYCLES cycles, so a monitor polling the pads cannot miss it.
module la_status_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 16,
  parameter int HOLD_CYCLES = 8,
  parameter int IDX_W       = 2
) (
  input logic                clock,
  input logic                resetb,
  la_status_arbiter_if.slave bus
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [IDX_W-1:0] ptr_r, ptr_s;
  logic [IDX_W-1:0] owner_r, owner_s;
  logic [WIDTH-1:0] status_r, status_s;
  logic [WIDTH-1:0] oeb_r, oeb_s;
  logic [N_REQ-1:0] gnt_r, gnt_s;
  logic [N_REQ-1:0] done_r, done_s;
  logic             busy_r, busy_s;
  logic [IDX_W-1:0] pick_s;
  logic             found_s;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = N_REQ'(1) << idx;
  endfunction

  // Round-robin search: first set request starting just after the last owner.
  always_comb begin
    int idx;
    found_s = 1'b0;
    pick_s  = {IDX_W{1'b0}};
    idx     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr_r) + k) % N_REQ;
      if (!found_s && bus.req[idx]) begin
        found_s = 1'b1;
        pick_s  = IDX_W'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and registered-output values for the IDLE/HOLD controller.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    ptr_s    = ptr_r;
    owner_s  = owner_r;
    status_s = status_r;
    oeb_s    = oeb_r;
    busy_s   = busy_r;
    gnt_s    = {N_REQ{1'b0}};
    done_s   = {N_REQ{1'b0}};
    case (state_r)
      IDLE: begin
        if (bus.enable && found_s) begin
          state_s  = HOLD;
          cnt_s    = CNT_W'(HOLD_CYCLES - 1);
          ptr_s    = pick_s;
          owner_s  = pick_s;
          status_s = bus.req_data[pick_s*WIDTH +: WIDTH];
          oeb_s    = {WIDTH{1'b0}};
          busy_s   = 1'b1;
          gnt_s    = onehot(pick_s);
        end else begin
          busy_s = 1'b0;
        end
      end
      HOLD: begin
        // Enable is deliberately not consulted here: a started hold always completes.
        if (cnt_r != {CNT_W{1'b0}}) begin
          cnt_s = cnt_r - CNT_W'(1);
        end else begin
          state_s = IDLE;
          busy_s  = 1'b0;
          done_s  = onehot(owner_r);
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Controller state and all outputs are registered; reset releases the pads.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      ptr_r    <= IDX_W'(N_REQ - 1);
      owner_r  <= {IDX_W{1'b0}};
      status_r <= {WIDTH{1'b0}};
      oeb_r    <= {WIDTH{1'b1}};
      busy_r   <= 1'b0;
      gnt_r    <= {N_REQ{1'b0}};
      done_r   <= {N_REQ{1'b0}};
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      ptr_r    <= ptr_s;
      owner_r  <= owner_s;
      status_r <= status_s;
      oeb_r    <= oeb_s;
      busy_r   <= busy_s;
      gnt_r    <= gnt_s;
      done_r   <= done_s;
    end
  end

  assign bus.gnt        = gnt_r;
  assign bus.done       = done_r;
  assign bus.status_out = status_r;
  assign bus.status_oeb = oeb_r;
  assign bus.busy       = busy_r;
  assign bus.owner      = owner_r;

endmodule

// File: tb/tb_la_status_arbiter.sv
// Directed bench for la_status_arbiter: reset, single requester, round-robin
// order, data stability, enable gating and asynchronous reset in mid-hold.
module tb_la_status_arbiter;

  localparam int HOLD = 8;

  logic clock;
  logic resetb;
  int   n_cmp;
  int   n_fail;

  la_status_arbiter_if #(.N_REQ(4), .WIDTH(16), .IDX_W(2)) bus ();

  la_status_arbiter #(
    .N_REQ(4), .WIDTH(16), .HOLD_CYCLES(HOLD), .IDX_W(2)
  ) dut (
    .clock (clock),
    .resetb(resetb),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input int own, input logic [15:0] data);
    chk("grant_gnt",   {28'd0, bus.gnt}, 32'(4'b0001 << own));
    chk("grant_owner", {30'd0, bus.owner}, 32'(own));
    chk("grant_data",  {16'd0, bus.status_out}, {16'd0, data});
    chk("grant_busy",  {31'd0, bus.busy}, 32'd1);
    chk("grant_oeb",   {16'd0, bus.status_oeb}, 32'h0000_0000);
  endtask

  // Runs the remainder of a hold after the grant edge has been checked.
  task automatic finish_hold(input int own, input logic [15:0] data, input bit mutate);
    for (int k = 1; k < HOLD; k++) begin
      if (mutate) bus.req_data[31:16] = 16'($urandom);
      tick();
      chk("hold_busy", {31'd0, bus.busy}, 32'd1);
      chk("hold_data", {16'd0, bus.status_out}, {16'd0, data});
      chk("hold_gnt",  {28'd0, bus.gnt}, 32'd0);
      chk("hold_done", {28'd0, bus.done}, 32'd0);
    end
    tick();
    chk("done_pulse", {28'd0, bus.done}, 32'(4'b0001 << own));
    chk("done_busy",  {31'd0, bus.busy}, 32'd0);
    chk("done_data",  {16'd0, bus.status_out}, {16'd0, data});
    chk("done_gnt",   {28'd0, bus.gnt}, 32'd0);
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    resetb       = 1'b0;
    bus.enable   = 1'b1;
    bus.req      = 4'b1111;
    bus.req_data = {16'hAB63, 16'hAB62, 16'hAB61, 16'hAB60};

    // Long reset with every request pending.
    #2000;
    chk("rst_gnt",   {28'd0, bus.gnt}, 32'd0);
    chk("rst_done",  {28'd0, bus.done}, 32'd0);
    chk("rst_data",  {16'd0, bus.status_out}, 32'h0000_0000);
    chk("rst_oeb",   {16'd0, bus.status_oeb}, 32'h0000_FFFF);
    chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
    chk("rst_owner", {30'd0, bus.owner}, 32'd0);
    resetb = 1'b1;
    tick();
    chk_grant(0, 16'hAB60);
    bus.req = 4'b0000;
    finish_hold(0, 16'hAB60, 1'b0);

    // Single requester, re-requesting during its own hold with a new word.
    bus.req_data[47:32] = 16'hAB60;
    bus.req = 4'b0100;
    tick();
    chk_grant(2, 16'hAB60);
    bus.req_data[47:32] = 16'hAB61;
    finish_hold(2, 16'hAB60, 1'b0);
    tick();
    chk_grant(2, 16'hAB61);
    bus.req = 4'b0000;
    finish_hold(2, 16'hAB61, 1'b0);

    // Fairness: last owner was 2, so order continues 3,0,1,2.
    bus.req_data[47:32] = 16'hAB62;
    bus.req = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk_grant((g + 3) % 4, 16'(16'hAB60 + ((g + 3) % 4)));
      finish_hold((g + 3) % 4, 16'(16'hAB60 + ((g + 3) % 4)), 1'b0);
    end

    // Data stability while requester 1's word changes every cycle.
    bus.req = 4'b0010;
    tick();
    chk_grant(1, 16'hAB61);
    bus.req = 4'b0000;
    finish_hold(1, 16'hAB61, 1'b1);
    bus.req_data[31:16] = 16'hAB61;

    // Enable dropped mid-hold: hold completes, pending request waits.
    bus.req = 4'b0001;
    tick();
    chk_grant(0, 16'hAB60);
    bus.enable = 1'b0;
    bus.req    = 4'b1000;
    finish_hold(0, 16'hAB60, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("dis_gnt",  {28'd0, bus.gnt}, 32'd0);
      chk("dis_busy", {31'd0, bus.busy}, 32'd0);
    end
    bus.enable = 1'b1;
    tick();
    chk_grant(3, 16'hAB63);
    bus.req = 4'b0000;
    finish_hold(3, 16'hAB63, 1'b0);

    // Asynchronous reset four cycles into a hold.
    bus.req = 4'b0100;
    tick();
    chk_grant(2, 16'hAB62);
    bus.req = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("pre_busy", {31'd0, bus.busy}, 32'd1);
    end
    #1;
    resetb = 1'b0;
    #1;
    chk("arst_data",  {16'd0, bus.status_out}, 32'h0000_0000);
    chk("arst_oeb",   {16'd0, bus.status_oeb}, 32'h0000_FFFF);
    chk("arst_busy",  {31'd0, bus.busy}, 32'd0);
    chk("arst_owner", {30'd0, bus.owner}, 32'd0);
    chk("arst_gnt",   {28'd0, bus.gnt}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("arst_done", {28'd0, bus.done}, 32'd0);
    end
    resetb  = 1'b1;
    bus.req = 4'b1111;
    tick();
    chk_grant(0, 16'hAB60);
    bus.req = 4'b0000;
    finish_hold(0, 16'hAB60, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
